// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and types for the timing generator and address generator.
// Pure declarations: no logic, no latency, no flow control.
`timescale 1ns/1ps
package vga_pkg;
   localparam int CNT_W = 10;

   localparam int VGA_CLK_DIV = 4;

   localparam int VGA_H_VIS   = 640;
   localparam int VGA_H_FP    = 16;
   localparam int VGA_H_SYNC  = 96;
   localparam int VGA_H_BP    = 48;
   localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int VGA_V_VIS   = 480;
   localparam int VGA_V_FP    = 10;
   localparam int VGA_V_SYNC  = 2;
   localparam int VGA_V_BP    = 33;
   localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam logic VGA_SYNC_POL = 1'b0;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic valid;
      logic line_start;
      logic frame_start;
   } raster_t;

   // Inclusive window test used for both sync pulses.
   function automatic logic in_window(input cnt_t c, input int lo, input int hi);
      return (c >= cnt_t'(lo)) && (c <= cnt_t'(hi));
   endfunction
endpackage

// File: rtl/pixel_tick_gen.sv
// Divides clk by CLK_DIV into a one-clk pixel strobe, combinational from the divider register.
// en=0 freezes the divider and masks the strobe; counting resumes from the held value.
`timescale 1ns/1ps
module pixel_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic pix_tick
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div;

   assign pix_tick = en && (div == DIV_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
      end else if (en) begin
         div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      end
   end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel tick, h/v counters, syncs, valid and line/frame strobes.
// All outputs update on the tick edge together; en=0 holds state and clears the strobes.
`timescale 1ns/1ps
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   CLK_DIV  = VGA_CLK_DIV,
   parameter int   H_VIS    = VGA_H_VIS,
   parameter int   H_FP     = VGA_H_FP,
   parameter int   H_SYNC   = VGA_H_SYNC,
   parameter int   H_BP     = VGA_H_BP,
   parameter int   V_VIS    = VGA_V_VIS,
   parameter int   V_FP     = VGA_V_FP,
   parameter int   V_SYNC   = VGA_V_SYNC,
   parameter int   V_BP     = VGA_V_BP,
   parameter logic SYNC_POL = VGA_SYNC_POL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             pix_tick,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             hsync,
   output logic             vsync,
   output logic             valid,
   output logic             line_start,
   output logic             frame_start
);
   localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_VIS + H_FP;
   localparam int HS_END   = HS_START + H_SYNC - 1;
   localparam int VS_START = V_VIS + V_FP;
   localparam int VS_END   = VS_START + V_SYNC - 1;

   localparam raster_t RST_RASTER = '{
      hsync:       ~SYNC_POL,
      vsync:       ~SYNC_POL,
      valid:       1'b0,
      line_start:  1'b0,
      frame_start: 1'b0
   };

   cnt_t    h_nxt;
   cnt_t    v_nxt;
   logic    h_wrap;
   logic    v_wrap;
   raster_t r_nxt;
   raster_t r_q;

   pixel_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_pixel_tick_gen (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .pix_tick (pix_tick)
   );

   always_comb begin
      h_nxt  = h_cnt;
      v_nxt  = v_cnt;
      h_wrap = (h_cnt == cnt_t'(H_TOTAL - 1));
      v_wrap = (v_cnt == cnt_t'(V_TOTAL - 1));
      if (pix_tick) begin
         if (h_wrap) begin
            h_nxt = '0;
            v_nxt = v_wrap ? '0 : v_cnt + cnt_t'(1);
         end else begin
            h_nxt = h_cnt + cnt_t'(1);
         end
      end
   end

   // Decoding the next counter values keeps every output aligned with h_cnt/v_cnt.
   always_comb begin
      r_nxt             = RST_RASTER;
      r_nxt.hsync       = in_window(h_nxt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      r_nxt.vsync       = in_window(v_nxt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      r_nxt.valid       = (h_nxt < cnt_t'(H_VIS)) && (v_nxt < cnt_t'(V_VIS));
      r_nxt.line_start  = pix_tick && h_wrap;
      r_nxt.frame_start = pix_tick && h_wrap && v_wrap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= cnt_t'(H_TOTAL - 1);
         v_cnt <= cnt_t'(V_TOTAL - 1);
         r_q   <= RST_RASTER;
      end else if (en) begin
         h_cnt <= h_nxt;
         v_cnt <= v_nxt;
         r_q   <= r_nxt;
      end else begin
         r_q.line_start  <= 1'b0;
         r_q.frame_start <= 1'b0;
      end
   end

   assign hsync       = r_q.hsync;
   assign vsync       = r_q.vsync;
   assign valid       = r_q.valid;
   assign line_start  = r_q.line_start;
   assign frame_start = r_q.frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for tick/line/hsync/enable/reset behaviour,
// reduced-geometry instance with a reference model for vsync and frame wrap.
`timescale 1ns/1ps
module tb_vga_timing_gen;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       rst_s = 1'b1;
   logic       en_s = 1'b1;

   logic       pix_tick, hsync, vsync, valid, line_start, frame_start;
   logic [9:0] h_cnt, v_cnt;
   logic       pix_s, hsync_s, vsync_s, valid_s, ls_s, fs_s;
   logic [9:0] h_s, v_s;

   int errors = 0;
   int checks = 0;

   // Reduced instance: H_TOTAL=16 (hsync 10..12), V_TOTAL=12 (vsync 8..9), CLK_DIV=2.
   int mdiv, mh, mv;
   logic mls, mfs;

   always #5 clk = ~clk;

   vga_timing_gen dut (
      .clk(clk), .rst(rst), .en(en), .pix_tick(pix_tick),
      .h_cnt(h_cnt), .v_cnt(v_cnt), .hsync(hsync), .vsync(vsync),
      .valid(valid), .line_start(line_start), .frame_start(frame_start)
   );

   vga_timing_gen #(
      .CLK_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
   ) dut_s (
      .clk(clk), .rst(rst_s), .en(en_s), .pix_tick(pix_s),
      .h_cnt(h_s), .v_cnt(v_s), .hsync(hsync_s), .vsync(vsync_s),
      .valid(valid_s), .line_start(ls_s), .frame_start(fs_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string ph);
      check({ph, "_h"}, h_cnt, 799);
      check({ph, "_v"}, v_cnt, 524);
      check({ph, "_hsync"}, hsync, 1);
      check({ph, "_vsync"}, vsync, 1);
      check({ph, "_valid"}, valid, 0);
      check({ph, "_ls"}, line_start, 0);
      check({ph, "_fs"}, frame_start, 0);
      check({ph, "_tick"}, pix_tick, 0);
   endtask

   task automatic do_reset_seq(input string ph);
      rst = 1'b1;
      repeat (5) step();
      check_reset_vals({ph, "_rst"});
      rst = 1'b0;
      repeat (3) step();
      check({ph, "_pre_tick"}, pix_tick, 1);
      check({ph, "_pre_h"}, h_cnt, 799);
      check({ph, "_pre_fs"}, frame_start, 0);
      step();
      check({ph, "_first_h"}, h_cnt, 0);
      check({ph, "_first_v"}, v_cnt, 0);
      check({ph, "_first_valid"}, valid, 1);
      check({ph, "_first_ls"}, line_start, 1);
      check({ph, "_first_fs"}, frame_start, 1);
      check({ph, "_first_tick"}, pix_tick, 0);
      check({ph, "_first_hsync"}, hsync, 1);
      step();
      check({ph, "_after_ls"}, line_start, 0);
      check({ph, "_after_fs"}, frame_start, 0);
      check({ph, "_after_h"}, h_cnt, 0);
   endtask

   task automatic run_to_h(input int target);
      int n = 0;
      while (h_cnt !== 10'(target) && n < 4000) begin
         step();
         n++;
      end
      check("reach_h", h_cnt, target);
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      while (pix_tick !== 1'b1 && n < 16) begin
         step();
         n++;
      end
      check("tick_found", pix_tick, 1);
   endtask

   task automatic model_reset_s();
      mdiv = 0; mh = 15; mv = 11; mls = 1'b0; mfs = 1'b0;
   endtask

   task automatic model_edge_s();
      logic tk;
      tk = (mdiv == 1);
      if (tk) begin
         mdiv = 0;
         if (mh == 15) begin
            mh = 0;
            mv = (mv == 11) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
      end else begin
         mdiv = mdiv + 1;
      end
      mls = tk && (mh == 0);
      mfs = tk && (mh == 0) && (mv == 0);
   endtask

   task automatic check_s(input string ph);
      check({ph, "_h"}, h_s, mh);
      check({ph, "_v"}, v_s, mv);
      check({ph, "_valid"}, valid_s, (mh < 8) && (mv < 6));
      check({ph, "_hsync"}, hsync_s, !((mh >= 10) && (mh <= 12)));
      check({ph, "_vsync"}, vsync_s, !((mv >= 8) && (mv <= 9)));
      check({ph, "_ls"}, ls_s, mls);
      check({ph, "_fs"}, fs_s, mfs);
      check({ph, "_tick"}, pix_s, mdiv == 1);
   endtask

   initial begin
      int n, eh, last_fs, nfs, vlow;

      // Reset values and first tick.
      do_reset_seq("init");

      // Tick spacing and h increment over 1000 ticks.
      for (int i = 0; i < 1000; i++) begin
         wait_tick(n);
         if (i > 0) check("tick_gap", n + 1, 4);
         eh = (int'(h_cnt) + 1) % 800;
         step();
         check("h_step", h_cnt, eh);
      end
      check("after_1000_h", h_cnt, 200);
      check("after_1000_v", v_cnt, 1);

      // Horizontal blanking and sync.
      run_to_h(639);
      check("valid_639", valid, 1);
      run_to_h(640);
      check("valid_640", valid, 0);
      run_to_h(655);
      check("hsync_655", hsync, 1);
      run_to_h(656);
      check("hsync_656", hsync, 0);
      n = 0;
      while (hsync !== 1'b1 && n < 500) begin
         step();
         n++;
      end
      check("hsync_low_clks", n, 384);
      check("hsync_rise_h", h_cnt, 752);
      run_to_h(0);
      check("wrap_ls", line_start, 1);
      check("wrap_fs", frame_start, 0);
      check("wrap_v", v_cnt, 2);

      // Enable hold with divider at 2.
      run_to_h(300);
      step();
      step();
      en = 1'b0;
      for (int i = 0; i < 37; i++) begin
         step();
         check("hold_h", h_cnt, 300);
         check("hold_tick", pix_tick, 0);
      end
      check("hold_v", v_cnt, 2);
      check("hold_valid", valid, 1);
      check("hold_hsync", hsync, 1);
      en = 1'b1;
      step();
      check("resume_tick", pix_tick, 1);
      check("resume_h_pre", h_cnt, 300);
      step();
      check("resume_h", h_cnt, 301);
      check("resume_tick_low", pix_tick, 0);

      // Mid-line asynchronous reset, then full restart.
      run_to_h(500);
      step();
      rst = 1'b1;
      #1;
      check_reset_vals("async");
      do_reset_seq("restart");

      // Reduced geometry: frame wrap, vsync window, frame period.
      step();
      model_reset_s();
      check_s("s_rst");
      rst_s = 1'b0;
      last_fs = -1;
      nfs = 0;
      vlow = 0;
      for (int c = 1; c <= 800; c++) begin
         step();
         model_edge_s();
         check_s("s_run");
         if (fs_s === 1'b1) begin
            if (last_fs < 0) check("s_first_fs", c, 2);
            else check("s_fs_gap", c - last_fs, 384);
            last_fs = c;
            nfs++;
         end
         if (nfs == 1 && vsync_s === 1'b0) vlow++;
      end
      check("s_fs_count", nfs, 3);
      check("s_vsync_low_clks", vlow, 64);

      n = 0;
      while (!(mh == 5 && mv == 3) && n < 1000) begin
         step();
         model_edge_s();
         check_s("s_seek");
         n++;
      end
      check("s_reach_h", h_s, 5);
      check("s_reach_v", v_s, 3);
      rst_s = 1'b1;
      #1;
      model_reset_s();
      check_s("s_async");
      repeat (3) begin
         step();
         check_s("s_hold_rst");
      end
      rst_s = 1'b0;
      repeat (10) begin
         step();
         model_edge_s();
         check_s("s_restart");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock. It produces the pixel-rate tick, the `h_cnt`/`v_cnt` counters consumed by the pixel address generator, the `hsync`/`vsync` pins and the active-video `valid` flag. It also emits line/frame start strobes for frame-synchronous logic. It sits directly upstream of the address generator and the RGB output mux.

## Interface
- `CLK_DIV`, 4: system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); legal values ≥2.
- `H_VIS`, `H_FP`, `H_SYNC`, `H_BP`: 640, 16, 96, 48. Horizontal visible pixels, front porch, sync width and back porch, in pixels.
- `V_VIS`, `V_FP`, `V_SYNC`, `V_BP`: 480, 10, 2, 33. Vertical visible lines, front porch, sync width and back porch, in lines.
- `SYNC_POL`, 0: active level of `hsync`/`vsync` (0 = active-low).

Ports:
- `clk` in 1: system clock; one clock domain only.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: run enable; when 0, all state holds.
- `pix_tick` out 1: one-`clk` pulse, once per `CLK_DIV` clocks.
- `h_cnt` out 10: horizontal position, 0..H_TOTAL-1 (H_TOTAL = 800).
- `v_cnt` out 10: vertical position, 0..V_TOTAL-1 (V_TOTAL = 525).
- `hsync` out 1: horizontal sync.
- `vsync` out 1: vertical sync.
- `valid` out 1: high when `h_cnt` < H_VIS and `v_cnt` < V_VIS.
- `line_start` out 1: one-`clk` pulse when `h_cnt` wraps to 0.
- `frame_start` out 1: one-`clk` pulse when (`h_cnt`, `v_cnt`) wraps to (0, 0).

## Operation
- The divider counter `div` runs 0..CLK_DIV-1 while `en`=1. `pix_tick` = (`div` == CLK_DIV-1) && `en`, and is combinational from the register.
- On each `clk` edge with `pix_tick`=1:
  - `h_cnt` increments.
  - At H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At V_TOTAL-1 with the h wrap, `v_cnt` wraps to 0.
- `hsync`, `vsync`, `valid`, `line_start` and `frame_start` are registered. They are computed from the next counter values, so they change on the same edge as the counters.
- Sync windows:
  - `hsync` is active for `h_cnt` in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656, 751].
  - `vsync` is active for `v_cnt` in [490, 491].
  - Outside these windows each sync sits at ~SYNC_POL.
- `line_start` is high for exactly one `clk` after the edge on which `h_cnt` became 0. `frame_start` is high for exactly one `clk` after the edge on which both counters became 0. On the frame wrap, both strobes are high together.
- `en`=0:
  - `div`, the counters and the sync/valid outputs hold.
  - `pix_tick`=0.
  - The strobes drop to 0 after one `clk`.
  - When `en` returns to 1, `div` resumes from its held value.
- Counter arithmetic is 10-bit unsigned. Counters never take values ≥ their TOTAL.

## Timing
- Reset values (forced immediately by asynchronous `rst`):
  - `div`=0, `h_cnt`=799, `v_cnt`=524.
  - `hsync`=`vsync`=~SYNC_POL, `valid`=0, `line_start`=`frame_start`=0.
- The first `pix_tick` after reset release occurs CLK_DIV `clk` cycles later. On that edge the counters go to (0, 0), `valid`=1, and `line_start`=`frame_start`=1 for one cycle.
- Latency from `pix_tick` to counter and output update is the same edge, i.e. all outputs are mutually aligned. The downstream address generator sees `valid` consistent with `h_cnt`/`v_cnt` in every cycle.
- Line period is 800 ticks = 3200 `clk`. Frame period is 420,000 ticks = 1,680,000 `clk`.
- `hsync` pulse width is 96 ticks = 384 `clk`. `vsync` pulse width is 2 lines = 1600 ticks.
- A `rst` asserted mid-frame returns the block to its reset values within the same cycle, with no partial strobe. After release, the block restarts as described above.

## Structure
- Shared package/include `vga_pkg`:
  - Timing constants: H/V visible, porch and sync values, H_TOTAL, V_TOTAL.
  - `CNT_W`=10.
  - The address generator uses the same constants.
- One natural sub-module: `pixel_tick_gen`, the `CLK_DIV` divider with `en`, which outputs `pix_tick`. The rest is the counter and decode logic in the top.

## Test plan
- Reset values and first tick: hold `rst` high for 5 cycles, then release. Outputs equal the reset values. After 4 `clk`, `h_cnt`=0, `v_cnt`=0, `valid`=1, and `frame_start` and `line_start` pulse for exactly 1 cycle.
- Tick spacing: `pix_tick` pulses are exactly 4 `clk` apart over 1000 ticks, and `h_cnt` steps by 1 per pulse.
- Horizontal sync: `hsync` falls on the edge where `h_cnt`=656 and rises where `h_cnt`=752 (384 `clk` low). `valid` falls at `h_cnt`=640.
- Frame wrap: `vsync` is low only for `v_cnt` 490–491. After `h_cnt`=799/`v_cnt`=524, the counters go to (0, 0) with `frame_start`=1. Successive `frame_start` pulses are 1,680,000 `clk` apart.
- Enable hold: drop `en` for 37 cycles at `h_cnt`=300. The counters, `div` and outputs are frozen and `pix_tick`=0. On resume, the next tick arrives after the remaining divider count.
- Mid-frame reset: assert `rst` at `v_cnt`=200, `h_cnt`=500. Outputs snap to the reset values in the same cycle, and the sequence restarts exactly as in the first scenario.
